// File: rtl/priority_queue_pkg.sv
// Shared types and the key-ordering helper for the sorted key/payload queue.
package priority_queue_pkg;

  typedef enum logic [2:0] {
    PQ_NOP     = 3'd0,
    PQ_PUSH    = 3'd1,
    PQ_POP     = 3'd2,
    PQ_REPLACE = 3'd3,
    PQ_FLUSH   = 3'd4
  } pq_op_e;

  // Keys up to 64 bits; callers zero-extend, compare is unsigned.
  function automatic logic pq_better(input logic [63:0] a, input logic [63:0] b,
                                     input logic max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/priority_queue_kv_if.sv
// Request/status bundle between a producer/consumer and priority_queue_kv.
interface priority_queue_kv_if #(
  parameter int KEY_W  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
);
  logic              i_push;
  logic [KEY_W-1:0]  i_key;
  logic [DATA_W-1:0] i_data;
  logic              i_pop;
  logic              i_flush;
  logic              o_head_valid;
  logic [KEY_W-1:0]  o_head_key;
  logic [DATA_W-1:0] o_head_data;
  logic [CNT_W-1:0]  o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_push_err;
  logic              o_pop_err;

  modport master (
    output i_push, i_key, i_data, i_pop, i_flush,
    input  o_head_valid, o_head_key, o_head_data, o_count, o_full, o_empty,
           o_push_err, o_pop_err
  );

  modport slave (
    input  i_push, i_key, i_data, i_pop, i_flush,
    output o_head_valid, o_head_key, o_head_data, o_count, o_full, o_empty,
           o_push_err, o_pop_err
  );
endinterface

// File: rtl/pq_cell.sv
// One sorted slot: picks its next content from itself, a neighbour or the new entry.
module pq_cell
  import priority_queue_pkg::*;
#(
  parameter int KEY_W     = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_FIRST = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  pq_op_e            op_i,
  input  logic [KEY_W-1:0]  new_key_i,
  input  logic [DATA_W-1:0] new_data_i,
  input  logic              left_v_i,
  input  logic [KEY_W-1:0]  left_key_i,
  input  logic [DATA_W-1:0] left_data_i,
  input  logic              left_ins_i,
  input  logic              right_v_i,
  input  logic [KEY_W-1:0]  right_key_i,
  input  logic [DATA_W-1:0] right_data_i,
  output logic              v_o,
  output logic [KEY_W-1:0]  key_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ins_o
);
  logic              v_q, v_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cmp_v;
  logic [KEY_W-1:0]  cmp_key;

  // Replace compares against the view after the head has shifted out.
  assign cmp_v   = (op_i == PQ_REPLACE) ? right_v_i   : v_q;
  assign cmp_key = (op_i == PQ_REPLACE) ? right_key_i : key_q;
  assign ins_o   = ((op_i == PQ_PUSH) || (op_i == PQ_REPLACE)) &&
                   (!cmp_v || pq_better(64'(new_key_i), 64'(cmp_key), MAX_FIRST != 0));

  always_comb begin
    v_d    = v_q;
    key_d  = key_q;
    data_d = data_q;
    case (op_i)
      PQ_FLUSH: v_d = 1'b0;
      PQ_POP: begin
        v_d = right_v_i; key_d = right_key_i; data_d = right_data_i;
      end
      PQ_PUSH: begin
        if (ins_o && left_ins_i) begin
          v_d = left_v_i; key_d = left_key_i; data_d = left_data_i;
        end else if (ins_o) begin
          v_d = 1'b1; key_d = new_key_i; data_d = new_data_i;
        end
      end
      PQ_REPLACE: begin
        if (!ins_o) begin
          v_d = right_v_i; key_d = right_key_i; data_d = right_data_i;
        end else if (!left_ins_i) begin
          v_d = 1'b1; key_d = new_key_i; data_d = new_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) v_q <= 1'b0;
    else       v_q <= v_d;
    key_q  <= key_d;
    data_q <= data_d;
  end

  assign v_o    = v_q;
  assign key_o  = key_q;
  assign data_o = data_q;
endmodule

// File: rtl/priority_queue_kv.sv
// Sorted register-array priority queue with FWFT head, replace, flush and error pulses.
module priority_queue_kv
  import priority_queue_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int KEY_W     = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_FIRST = 0
) (
  input  logic               CLK,
  input  logic               RST,
  priority_queue_kv_if.slave q
);
  localparam int CNT_W = $clog2(DEPTH+1);

  pq_op_e                        op;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          push_err_q, push_err_d, pop_err_q, pop_err_d;
  logic                          full, empty;
  logic [DEPTH-1:0]              v, ins, v_l, v_r, ins_l;
  logic [DEPTH-1:0][KEY_W-1:0]   key, key_l, key_r;
  logic [DEPTH-1:0][DATA_W-1:0]  data, data_l, data_r;
  logic                          unused_ins;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    op         = PQ_NOP;
    push_err_d = 1'b0;
    pop_err_d  = 1'b0;
    if (q.i_flush) begin
      op = PQ_FLUSH;
    end else if (q.i_push && q.i_pop) begin
      // Replace on an empty queue degrades to a plain push plus a pop error.
      if (empty) begin op = PQ_PUSH; pop_err_d = 1'b1; end
      else       op = PQ_REPLACE;
    end else if (q.i_push) begin
      if (full) push_err_d = 1'b1;
      else      op = PQ_PUSH;
    end else if (q.i_pop) begin
      if (empty) pop_err_d = 1'b1;
      else       op = PQ_POP;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (op)
      PQ_PUSH:  cnt_d = cnt_q + CNT_W'(1);
      PQ_POP:   cnt_d = cnt_q - CNT_W'(1);
      PQ_FLUSH: cnt_d = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      push_err_q <= 1'b0;
      pop_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      push_err_q <= push_err_d;
      pop_err_q  <= pop_err_d;
    end
  end

  // Neighbour views; slot 0 has no left, the last slot sees an empty right.
  assign v_l    = {v[DEPTH-2:0], 1'b0};
  assign key_l  = {key[DEPTH-2:0], KEY_W'(0)};
  assign data_l = {data[DEPTH-2:0], DATA_W'(0)};
  assign ins_l  = {ins[DEPTH-2:0], 1'b0};
  assign v_r    = {1'b0, v[DEPTH-1:1]};
  assign key_r  = {KEY_W'(0), key[DEPTH-1:1]};
  assign data_r = {DATA_W'(0), data[DEPTH-1:1]};
  assign unused_ins = ins[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    pq_cell #(.KEY_W(KEY_W), .DATA_W(DATA_W), .MAX_FIRST(MAX_FIRST)) u_cell (
      .clk_i       (CLK),
      .rst_i       (RST),
      .op_i        (op),
      .new_key_i   (q.i_key),
      .new_data_i  (q.i_data),
      .left_v_i    (v_l[i]),
      .left_key_i  (key_l[i]),
      .left_data_i (data_l[i]),
      .left_ins_i  (ins_l[i]),
      .right_v_i   (v_r[i]),
      .right_key_i (key_r[i]),
      .right_data_i(data_r[i]),
      .v_o         (v[i]),
      .key_o       (key[i]),
      .data_o      (data[i]),
      .ins_o       (ins[i])
    );
  end

  assign q.o_head_valid = v[0];
  assign q.o_head_key   = key[0];
  assign q.o_head_data  = data[0];
  assign q.o_count      = cnt_q;
  assign q.o_full       = full;
  assign q.o_empty      = empty;
  assign q.o_push_err   = push_err_q;
  assign q.o_pop_err    = pop_err_q;
endmodule
